// File: rtl/regfile_arb_pkg.sv
// rtl/regfile_arb_pkg.sv - shared state encoding, default widths and id-width helper for the register-file port arbiter
package regfile_arb_pkg;

  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

  // Width of a requester index; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regfile_port_arbiter_if.sv
// rtl/regfile_port_arbiter_if.sv - requester, register-file and response signals of the port arbiter
interface regfile_port_arbiter_if
  import regfile_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W
);

  localparam int ID_W = id_width(NUM_REQ);

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        req_we;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        gnt;

  logic                      rf_write_en;
  logic [ADDR_W-1:0]         rf_write_line;
  logic [DATA_W-1:0]         rf_wdata;
  logic                      rf_read_en;
  logic [ADDR_W-1:0]         rf_read_line;
  logic [DATA_W-1:0]         rf_rdata;

  logic                      rsp_valid;
  logic [ID_W-1:0]           rsp_id;
  logic [DATA_W-1:0]         rsp_data;
  logic                      busy;

  // Requesters plus register file: drive requests and read data, observe the rest.
  modport master (
    output req, req_we, req_addr, req_wdata, rf_rdata,
    input  gnt, rf_write_en, rf_write_line, rf_wdata, rf_read_en, rf_read_line,
           rsp_valid, rsp_id, rsp_data, busy
  );

  // The arbiter itself.
  modport slave (
    input  req, req_we, req_addr, req_wdata, rf_rdata,
    output gnt, rf_write_en, rf_write_line, rf_wdata, rf_read_en, rf_read_line,
           rsp_valid, rsp_id, rsp_data, busy
  );

endinterface

// File: rtl/regfile_port_arbiter_rr_pick.sv
// rtl/regfile_port_arbiter_rr_pick.sv - combinational round-robin winner: first set mask bit at or after ptr
module rr_pick #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   mask,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   onehot,
  output logic [IDW-1:0] idx,
  output logic           any
);

  // Scan N positions starting at ptr, wrapping, and keep the first hit.
  always_comb begin
    int j;
    logic [IDW-1:0] jj;
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    j      = 0;
    jj     = '0;
    for (int i = 0; i < N; i++) begin
      j  = (int'(ptr) + i) % N;
      jj = IDW'(j);
      if (!any && mask[jj]) begin
        any        = 1'b1;
        onehot[jj] = 1'b1;
        idx        = jj;
      end
    end
  end

endmodule

// File: rtl/regfile_port_arbiter.sv
// rtl/regfile_port_arbiter.sv - round-robin sharing of one register-file write port and one read port; optional RFARB_WR_PRIORITY_EN favours writers
module regfile_port_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int RD_LAT  = 1
) (
  input logic                  clk,
  input logic                  reset,
  regfile_port_arbiter_if.slave bus
);

  localparam int IDW = id_width(NUM_REQ);

  arb_state_t         state_q, state_n;
  logic [IDW-1:0]     ptr_q, ptr_n;
  logic [IDW-1:0]     win_q, win_n;
  logic [2:0]         cnt_q, cnt_n;

  logic [NUM_REQ-1:0] gnt_q, gnt_n;
  logic               we_q, we_n;
  logic [ADDR_W-1:0]  wline_q, wline_n;
  logic [DATA_W-1:0]  wdata_q, wdata_n;
  logic               re_q, re_n;
  logic [ADDR_W-1:0]  rline_q, rline_n;
  logic               rsp_valid_q, rsp_valid_n;
  logic [IDW-1:0]     rsp_id_q, rsp_id_n;
  logic [DATA_W-1:0]  rsp_data_q, rsp_data_n;
  logic               busy_q, busy_n;

  logic [NUM_REQ-1:0] pick_mask;
  logic [NUM_REQ-1:0] pick_onehot;
  logic [IDW-1:0]     pick_idx;
  logic               pick_any;

  // Candidate set for arbitration; with writer priority, readers only compete when no writer is pending.
  always_comb begin
    pick_mask = bus.req;
`ifdef RFARB_WR_PRIORITY_EN
    if (|(bus.req & bus.req_we)) begin
      pick_mask = bus.req & bus.req_we;
    end
`endif
  end

  rr_pick #(
    .N   (NUM_REQ),
    .IDW (IDW)
  ) u_rr_pick (
    .mask   (pick_mask),
    .ptr    (ptr_q),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // Next state and next registered outputs; line/data/response fields hold unless refreshed.
  always_comb begin
    state_n     = state_q;
    ptr_n       = ptr_q;
    win_n       = win_q;
    cnt_n       = cnt_q;
    gnt_n       = '0;
    we_n        = 1'b0;
    wline_n     = wline_q;
    wdata_n     = wdata_q;
    re_n        = 1'b0;
    rline_n     = rline_q;
    rsp_valid_n = 1'b0;
    rsp_id_n    = rsp_id_q;
    rsp_data_n  = rsp_data_q;

    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_n = ST_ISSUE;
          gnt_n   = pick_onehot;
          win_n   = pick_idx;
          ptr_n   = (pick_idx == IDW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
          if (bus.req_we[pick_idx]) begin
            we_n    = 1'b1;
            wline_n = bus.req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
            wdata_n = bus.req_wdata[int'(pick_idx)*DATA_W +: DATA_W];
          end else begin
            re_n    = 1'b1;
            rline_n = bus.req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
          end
        end
      end
      ST_ISSUE: begin
        // re_q is high exactly when the issued access was a read.
        if (re_q) begin
          state_n = ST_WAIT;
          cnt_n   = 3'(RD_LAT - 1);
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 3'd0) begin
          state_n     = ST_RESP;
          rsp_valid_n = 1'b1;
          rsp_id_n    = win_q;
          rsp_data_n  = bus.rf_rdata;
        end else begin
          cnt_n = cnt_q - 3'd1;
        end
      end
      ST_RESP: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase

    busy_n = (state_n != ST_IDLE);
  end

  // State register and output registers; reset abandons any in-flight read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      win_q       <= '0;
      cnt_q       <= '0;
      gnt_q       <= '0;
      we_q        <= 1'b0;
      wline_q     <= '0;
      wdata_q     <= '0;
      re_q        <= 1'b0;
      rline_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_n;
      ptr_q       <= ptr_n;
      win_q       <= win_n;
      cnt_q       <= cnt_n;
      gnt_q       <= gnt_n;
      we_q        <= we_n;
      wline_q     <= wline_n;
      wdata_q     <= wdata_n;
      re_q        <= re_n;
      rline_q     <= rline_n;
      rsp_valid_q <= rsp_valid_n;
      rsp_id_q    <= rsp_id_n;
      rsp_data_q  <= rsp_data_n;
      busy_q      <= busy_n;
    end
  end

  assign bus.gnt           = gnt_q;
  assign bus.rf_write_en   = we_q;
  assign bus.rf_write_line = wline_q;
  assign bus.rf_wdata      = wdata_q;
  assign bus.rf_read_en    = re_q;
  assign bus.rf_read_line  = rline_q;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_id        = rsp_id_q;
  assign bus.rsp_data      = rsp_data_q;
  assign bus.busy          = busy_q;

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// tb/tb_regfile_port_arbiter.sv - vector table plus response scoreboard for regfile_port_arbiter
module tb_regfile_port_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 4;
  localparam int DATA_W  = 32;
  localparam int RD_LAT  = 1;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  // 10 ns clock.
  always #5 clk = ~clk;

  regfile_port_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  regfile_port_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .RD_LAT  (RD_LAT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [DATA_W-1:0] rf_mem [16];
  logic [DATA_W-1:0] rf_rdata_q = '0;
  assign bus.rf_rdata = rf_rdata_q;

  // Register-file model with one cycle of read latency.
  always @(posedge clk) begin
    if (bus.rf_write_en) rf_mem[bus.rf_write_line] <= bus.rf_wdata;
    if (bus.rf_read_en) rf_rdata_q <= rf_mem[bus.rf_read_line];
  end

  int cyc = 0;

  // Cycle counter used for latency checks.
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int              id;
    logic [DATA_W-1:0] data;
    int              cyc;
  } rsp_exp_t;

  rsp_exp_t sb[$];
  rsp_exp_t mon_e;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Response scoreboard and strobe exclusivity, sampled mid-cycle.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.rf_write_en || bus.rf_read_en)
        check("strobe_excl", 64'(bus.rf_write_en & bus.rf_read_en), 64'd0);
      if (bus.rsp_valid) begin
        if (sb.size() == 0) begin
          check("rsp_unexpected", 64'(bus.rsp_valid), 64'd0);
        end else begin
          mon_e = sb.pop_front();
          check("rsp_id", 64'(bus.rsp_id), 64'(mon_e.id));
          check("rsp_data", 64'(bus.rsp_data), 64'(mon_e.data));
          check("rsp_cycle", 64'(cyc), 64'(mon_e.cyc));
        end
      end
    end
  end

  task automatic wait_gnt(output int gcyc, output logic [NUM_REQ-1:0] g, output bit ok);
    ok   = 1'b0;
    g    = '0;
    gcyc = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.gnt != '0) begin
        ok   = 1'b1;
        g    = bus.gnt;
        gcyc = cyc;
        break;
      end
    end
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (!bus.busy) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, 64'(ok), 64'd1);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_ctl"}, 64'({bus.gnt, bus.rf_write_en, bus.rf_read_en, bus.rsp_valid,
                               bus.rsp_id, bus.busy, bus.rf_write_line, bus.rf_read_line}), 64'd0);
    check({name, "_data"}, 64'(bus.rf_wdata | bus.rsp_data), 64'd0);
  endtask

  task automatic do_txn(input int id, input bit we, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] data);
    int                 start;
    int                 gcyc;
    logic [NUM_REQ-1:0] g;
    bit                 ok;
    @(posedge clk);
    #1;
    start                                = cyc;
    bus.req_we[id]                       = we;
    bus.req_addr[id*ADDR_W +: ADDR_W]    = addr;
    bus.req_wdata[id*DATA_W +: DATA_W]   = we ? data : DATA_W'($urandom);
    bus.req[id]                          = 1'b1;
    wait_gnt(gcyc, g, ok);
    check("gnt_seen", 64'(ok), 64'd1);
    if (ok) begin
      check("gnt_onehot", 64'(g), 64'(1 << id));
      check("gnt_latency", 64'(gcyc), 64'(start + 1));
      check("wr_en", 64'(bus.rf_write_en), 64'(we));
      check("rd_en", 64'(bus.rf_read_en), 64'(!we));
      check("busy_issue", 64'(bus.busy), 64'd1);
      if (we) begin
        check("wr_line", 64'(bus.rf_write_line), 64'(addr));
        check("wr_data", 64'(bus.rf_wdata), 64'(data));
      end else begin
        check("rd_line", 64'(bus.rf_read_line), 64'(addr));
        sb.push_back('{id, data, gcyc + 1 + RD_LAT});
      end
    end
    bus.req[id] = 1'b0;
    wait_idle("idle_after_txn");
    if (we) check("rf_landed", 64'(rf_mem[addr]), 64'(data));
  endtask

  typedef struct {
    int                id;
    bit                we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;  // write data, or expected read data
  } vec_t;

  vec_t vecs[8];

  initial begin : stim
    int                 gcyc;
    logic [NUM_REQ-1:0] g;
    logic [NUM_REQ-1:0] g2;
    logic [NUM_REQ-1:0] gseq [5];
    int                 gc [5];
    int                 n;
    bit                 ok;
    bit                 seen3;
    logic [NUM_REQ-1:0] exp_first;

    bus.req       = '0;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;

    vecs[0] = '{2, 1'b1, 4'h2, 32'h0000_ffff};
    vecs[1] = '{1, 1'b0, 4'h2, 32'h0000_ffff};
    vecs[2] = '{0, 1'b1, 4'h5, 32'ha5a5_5a5a};
    vecs[3] = '{3, 1'b1, 4'hf, 32'hdead_beef};
    vecs[4] = '{3, 1'b0, 4'h5, 32'ha5a5_5a5a};
    vecs[5] = '{0, 1'b0, 4'hf, 32'hdead_beef};
    vecs[6] = '{1, 1'b1, 4'h0, 32'h1234_5678};
    vecs[7] = '{2, 1'b0, 4'h0, 32'h1234_5678};

    // Power-on reset.
    repeat (2) @(negedge clk);
    check_all_zero("reset_init");
    reset = 1'b0;

    for (int v = 0; v < 8; v++) begin
      do_txn(vecs[v].id, vecs[v].we, vecs[v].addr, vecs[v].data);
    end
    check("sb_empty_table", 64'(sb.size()), 64'd0);

    // Reset asserted while a read is in flight.
    @(posedge clk);
    #1;
    bus.req_we[1]        = 1'b0;
    bus.req_addr[7:4]    = 4'h2;
    bus.req[1]           = 1'b1;
    wait_gnt(gcyc, g, ok);
    check("midrd_gnt", 64'(g), 64'b0010);
    bus.req[1] = 1'b0;
    reset      = 1'b1;
    #20;
    check_all_zero("reset_midread");
    reset = 1'b0;
    repeat (8) @(negedge clk);
    check("midrd_busy", 64'(bus.busy), 64'd0);
    check("midrd_rsp_valid", 64'(bus.rsp_valid), 64'd0);

    // Round-robin with all four writers held; pointer restarts at 0 after reset.
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_addr[i*ADDR_W +: ADDR_W]   = ADDR_W'(8 + i);
      bus.req_wdata[i*DATA_W +: DATA_W]  = 32'h1000_0000 + DATA_W'(i);
    end
    bus.req_we = '1;
    bus.req    = '1;
    n = 0;
    for (int k = 0; k < 20 && n < 5; k++) begin
      @(negedge clk);
      if (bus.gnt != '0) begin
        gseq[n] = bus.gnt;
        gc[n]   = cyc;
        n++;
      end
    end
    bus.req = '0;
    check("rr_count", 64'(n), 64'd5);
    for (int k = 0; k < n; k++) begin
      check("rr_order", 64'(gseq[k]), 64'(1 << (k % NUM_REQ)));
      if (k > 0) check("rr_spacing", 64'(gc[k] - gc[k-1]), 64'd2);
    end
    wait_idle("idle_after_rr");
    for (int i = 0; i < NUM_REQ; i++) begin
      check("rr_rf_data", 64'(rf_mem[8+i]), 64'(32'h1000_0000 + i));
    end

    // Request withdrawn while another requester is in ISSUE.
    @(posedge clk);
    #1;
    bus.req_we       = 4'b1001;
    bus.req_addr     = {4'hd, 4'h0, 4'h0, 4'hc};
    bus.req_wdata[31:0] = 32'h00c0_ffee;
    bus.req[0]       = 1'b1;
    wait_gnt(gcyc, g, ok);
    check("wd_gnt0", 64'(g), 64'b0001);
    bus.req[0] = 1'b0;
    bus.req[3] = 1'b1;
    @(posedge clk);
    #1;
    bus.req[3] = 1'b0;
    seen3 = 1'b0;
    repeat (8) begin
      @(negedge clk);
      seen3 = seen3 | bus.gnt[3];
    end
    check("wd_no_gnt3", 64'(seen3), 64'd0);
    check("wd_rf_data", 64'(rf_mem[12]), 64'h00c0_ffee);

    // Reader 0 and writer 1 requesting together, pointer at 0.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
`ifdef RFARB_WR_PRIORITY_EN
    exp_first = 4'b0010;
`else
    exp_first = 4'b0001;
`endif
    @(posedge clk);
    #1;
    bus.req_we          = 4'b0010;
    bus.req_addr        = {4'h0, 4'h0, 4'h6, 4'h5};
    bus.req_wdata[63:32] = 32'h6666_6666;
    bus.req             = 4'b0011;
    wait_gnt(gcyc, g, ok);
    check("prio_first", 64'(g), 64'(exp_first));
    if (g == 4'b0001) sb.push_back('{0, 32'ha5a5_5a5a, gcyc + 1 + RD_LAT});
    bus.req = bus.req & ~g;
    wait_gnt(gcyc, g2, ok);
    check("prio_second", 64'(g2), 64'(4'b0011 & ~exp_first));
    if (g2 == 4'b0001) sb.push_back('{0, 32'ha5a5_5a5a, gcyc + 1 + RD_LAT});
    bus.req = '0;
    wait_idle("idle_after_prio");
    check("prio_rf_data", 64'(rf_mem[6]), 64'h6666_6666);
    repeat (2) @(negedge clk);
    check("sb_empty_end", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1);
  end

endmodule
